// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// DUT side uses slave, the driver side uses master.
interface instr_encoder_if #(
  parameter int CNT_W = 16
);
  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_fmt;
  logic [6:0]       i_opcode;
  logic [2:0]       i_funct3;
  logic [6:0]       i_funct7;
  logic [4:0]       i_rd;
  logic [4:0]       i_rs1;
  logic [4:0]       i_rs2;
  logic [31:0]      i_imm;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_instr;
  logic             o_illegal;
  logic [CNT_W-1:0] o_count;

  modport slave (
    input  i_valid, i_fmt, i_opcode, i_funct3,
    input  i_funct7, i_rd, i_rs1, i_rs2,
    input  i_imm, i_ready,
    output o_ready, o_valid, o_instr,
    output o_illegal, o_count
  );

  modport master (
    output i_valid, i_fmt, i_opcode, i_funct3,
    output i_funct7, i_rd, i_rs1, i_rs2,
    output i_imm, i_ready,
    input  o_ready, o_valid, o_instr,
    input  o_illegal, o_count
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field-set to instruction-word encoder with
// an output FIFO, illegal pulse and delivery counter.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic            i_clk,
  input logic            i_rst_n,
  instr_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic [31:0]      mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             up_q;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        full, empty;
  logic        fire_in, fire_out;
  logic        illegal;
  logic        push;
  logic [31:0] word;
  logic [31:0] imm;

  assign imm = bus.i_imm;

  // Extra pointer bit separates full from empty.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // Ready depends only on occupancy and reset release.
  assign bus.o_ready = up_q && !full;
  assign bus.o_valid = !empty;
  assign bus.o_instr = empty ? 32'h0
                             : mem_q[rd_q[AW-1:0]];
  assign bus.o_illegal = ill_q;
  assign bus.o_count   = cnt_q;

  assign fire_in  = bus.i_valid && bus.o_ready;
  assign fire_out = bus.o_valid && bus.i_ready;
  assign push     = fire_in && !illegal;

  // Format decode: pack fields and flag bad requests.
  always_comb begin
    word    = 32'h0;
    illegal = (bus.i_opcode[1:0] != 2'b11);
    unique case (bus.i_fmt)
      FMT_R: word = {bus.i_funct7, bus.i_rs2,
                     bus.i_rs1, bus.i_funct3,
                     bus.i_rd, bus.i_opcode};
      FMT_I: word = {imm[11:0], bus.i_rs1,
                     bus.i_funct3, bus.i_rd,
                     bus.i_opcode};
      FMT_S: word = {imm[11:5], bus.i_rs2,
                     bus.i_rs1, bus.i_funct3,
                     imm[4:0], bus.i_opcode};
      FMT_B: begin
        word = {imm[12], imm[10:5], bus.i_rs2,
                bus.i_rs1, bus.i_funct3,
                imm[4:1], imm[11], bus.i_opcode};
        if (imm[0]) illegal = 1'b1;
      end
      FMT_U: word = {imm[31:12], bus.i_rd,
                     bus.i_opcode};
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11],
                imm[19:12], bus.i_rd,
                bus.i_opcode};
        if (imm[0]) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Pointer, pulse and counter next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ill_d = fire_in && illegal;
    if (push)     wr_d  = wr_q + 1'b1;
    if (fire_out) begin
      rd_d  = rd_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Control state; reset drops every queued word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      up_q  <= 1'b0;
      ill_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      up_q  <= 1'b1;
      ill_q <= ill_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; reads are masked when empty.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= word;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-002 Parameter CNT_W, default 16, width of emitted-instruction counter.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_valid  input  1  request carries a field set to encode.
REQ-006 o_ready  output  1  encoder can accept a request this cycle.
REQ-007 i_fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 reserved.
REQ-008 i_opcode  input  7  instruction bits [6:0].
REQ-009 i_funct3  input  3  bits [14:12] (R/I/S/B only).
REQ-010 i_funct7  input  7  bits [31:25] (R only).
REQ-011 i_rd, i_rs1, i_rs2  input  5 each  register indices.
REQ-012 i_imm  input  32  immediate as a byte-offset/value (U: upper 20 bits meaningful).
REQ-013 o_valid  output  1  o_instr holds an encoded word.
REQ-014 i_ready  input  1  consumer accepts o_instr this cycle.
REQ-015 o_instr  output  32  encoded RV32I instruction word (FIFO head).
REQ-016 o_illegal  output  1  one-cycle pulse: accepted request was rejected.
REQ-017 o_count  output  CNT_W  number of instructions delivered.

Function
REQ-018 Input handshake fires when i_valid && o_ready; output handshake when o_valid && i_ready.
REQ-019 o_ready SHALL be !full only; no combinational path from i_ready to o_ready.
REQ-020 R: {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-021 I: {imm[11:0], rs1, funct3, rd, opcode}.
REQ-022 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-023 B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-024 U: {imm[31:12], rd, opcode}.
REQ-025 J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-026 Illegal if i_fmt is 6/7, i_opcode[1:0] != 2'b11, or B/J with i_imm[0] = 1.
REQ-027 Illegal request is consumed (handshake completes), not enqueued; o_illegal pulses high the following cycle.
REQ-028 Legal request is written into the FIFO at the handshake edge; with FIFO empty it appears on o_instr with o_valid = 1 the next cycle (latency 1).
REQ-029 FIFO is in-order; o_instr and o_valid stable while o_valid && !i_ready.
REQ-030 Simultaneous push and pop: allowed when not full; occupancy unchanged; no data loss or duplication.
REQ-031 Full (DEPTH entries): o_ready = 0 even if i_ready = 1 that cycle.
REQ-032 Empty: o_valid = 0; o_instr value is don't-care but must not be X after reset.
REQ-033 o_count increments by 1 per output handshake, wraps 2^CNT_W-1 -> 0.
REQ-034 Read/write pointers wrap modulo DEPTH; full/empty distinguished by an extra pointer bit or occupancy count.

Reset
REQ-035 While i_rst_n = 0: o_valid = 0, o_ready = 0, o_illegal = 0, o_count = 0, o_instr = 0, FIFO empty.
REQ-036 o_ready SHALL rise on the first rising i_clk edge after i_rst_n deasserts.
REQ-037 Reset mid-operation discards all queued entries and any pending o_illegal pulse immediately.

Verification
REQ-038 R, op 0x33, f3 0, f7 0, rd 3, rs1 1, rs2 2 -> o_instr 0x002081B3 one cycle later, o_valid 1.
REQ-039 I 0x13 rd1 imm5 -> 0x00500093; S 0x23 f3 2 rs1 1 rs2 2 imm 4 -> 0x0020A223; U 0x37 rd5 imm 0x12345000 -> 0x123452B7.
REQ-040 B 0x63 f3 0 rs1 0 rs2 0 imm 8 -> 0x00000463; J 0x6F rd 1 imm 16 -> 0x010000EF; B with imm 7 -> o_illegal pulse, nothing queued.
REQ-041 Hold i_ready 0, push 4 legal -> o_ready 0 after 4th; 5th held; raise i_ready -> 4 words in order, then 5th accepted.
REQ-042 Continuous i_valid and i_ready for 100 cycles -> one word per cycle, o_count = 99 at the end; CNT_W = 4 bench -> wrap 15 -> 0.
REQ-043 Assert i_rst_n = 0 with 3 entries queued -> o_valid 0 and o_count 0 asynchronously; no stale word after release.
